// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings and frame constants for the display UART receiver
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    P_HUNT = 2'd0,
    P_DATA = 2'd1,
    P_CHK  = 2'd2
  } parse_state_t;

  localparam logic [7:0] HEADER           = 8'hA5;
  localparam int         FRAME_DATA_BYTES = 4;

endpackage

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 2-flop synchroniser and 8N1 byte deserialiser
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int BIT_CNT_MAX = 433
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Uart_Rx,
  output logic [7:0] Rx_Byte,
  output logic       Rx_Byte_Valid,
  output logic       stop_err
);

  localparam int               CNT_W    = $clog2(BIT_CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BIT_CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CNT_MAX / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  rx_state_t        state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_prev       <= 1'b1;
      state         <= RX_IDLE;
      bit_cnt       <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      Rx_Byte       <= '0;
      Rx_Byte_Valid <= 1'b0;
      stop_err      <= 1'b0;
    end else begin
      Rx_Byte_Valid <= 1'b0;
      stop_err      <= 1'b0;
      rx_meta       <= Uart_Rx;
      rx_sync       <= rx_meta;
      rx_prev       <= rx_sync;
      case (state)
        // Edge detect means a line stuck low after a framing error is not re-armed.
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state   <= RX_START;
            bit_cnt <= '0;
          end
        end
        RX_START: begin
          if (bit_cnt == CNT_HALF) begin
            bit_cnt <= '0;
            if (rx_sync) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (bit_cnt == CNT_FULL) begin
            bit_cnt <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (bit_cnt == CNT_FULL) begin
            bit_cnt <= '0;
            state   <= RX_IDLE;
            if (rx_sync) begin
              Rx_Byte       <= shreg;
              Rx_Byte_Valid <= 1'b1;
            end else begin
              stop_err <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_disp_rx.sv
// rtl/uart_disp_rx.sv - UART frame parser loading the 32-bit hex display word
module uart_disp_rx
  import uart_pkg::parse_state_t, uart_pkg::P_HUNT, uart_pkg::P_DATA, uart_pkg::P_CHK,
         uart_pkg::FRAME_DATA_BYTES;
#(
  parameter int         CLOCK_FREQ    = 50_000_000,
  parameter int         BAUD          = 115200,
  parameter int         FRAME_TIMEOUT = CLOCK_FREQ / 100,
  parameter logic [7:0] HEADER        = uart_pkg::HEADER
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Uart_Rx,
  output logic [31:0] Disp_Data,
  output logic        Frame_Done,
  output logic        Frame_Err,
  output logic [7:0]  Rx_Byte,
  output logic        Rx_Byte_Valid
);

  localparam int               BIT_CNT_MAX = CLOCK_FREQ / BAUD - 1;
  localparam int               TMO_W       = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(FRAME_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE     = TMO_W'(1);
  localparam logic [1:0]       IDX_LAST    = 2'(FRAME_DATA_BYTES - 1);

  logic             stop_err;
  parse_state_t     pstate;
  logic [1:0]       byte_idx;
  logic [7:0]       acc;
  logic [31:0]      shadow;
  logic [TMO_W-1:0] tmo_cnt;

  uart_byte_rx #(
    .BIT_CNT_MAX(BIT_CNT_MAX)
  ) u_byte_rx (
    .Clk          (Clk),
    .Reset        (Reset),
    .Uart_Rx      (Uart_Rx),
    .Rx_Byte      (Rx_Byte),
    .Rx_Byte_Valid(Rx_Byte_Valid),
    .stop_err     (stop_err)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pstate     <= P_HUNT;
      byte_idx   <= '0;
      acc        <= '0;
      shadow     <= '0;
      tmo_cnt    <= '0;
      Disp_Data  <= '0;
      Frame_Done <= 1'b0;
      Frame_Err  <= 1'b0;
    end else begin
      Frame_Done <= 1'b0;
      Frame_Err  <= 1'b0;
      if (stop_err) begin
        pstate    <= P_HUNT;
        tmo_cnt   <= '0;
        Frame_Err <= 1'b1;
      end else if (Rx_Byte_Valid) begin
        // A byte arriving on the timeout terminal count takes priority over the timeout.
        tmo_cnt <= '0;
        case (pstate)
          P_HUNT: begin
            if (Rx_Byte == HEADER) begin
              pstate   <= P_DATA;
              byte_idx <= '0;
              acc      <= '0;
            end
          end
          P_DATA: begin
            shadow <= {shadow[23:0], Rx_Byte};
            acc    <= acc ^ Rx_Byte;
            if (byte_idx == IDX_LAST) pstate <= P_CHK;
            else                      byte_idx <= byte_idx + 2'd1;
          end
          P_CHK: begin
            if (Rx_Byte == acc) begin
              Disp_Data  <= shadow;
              Frame_Done <= 1'b1;
            end else begin
              Frame_Err <= 1'b1;
            end
            pstate <= P_HUNT;
          end
          default: pstate <= P_HUNT;
        endcase
      end else if (pstate != P_HUNT) begin
        if (tmo_cnt == TMO_LAST) begin
          tmo_cnt   <= '0;
          pstate    <= P_HUNT;
          Frame_Err <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_ONE;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_disp_rx.sv
// tb/tb_uart_disp_rx.sv - directed scoreboard bench for uart_disp_rx
module tb_uart_disp_rx;

  localparam int CLOCK_FREQ = 1_600_000;
  localparam int BAUD       = 100_000;
  localparam int BIT_CLKS   = CLOCK_FREQ / BAUD;
  localparam int TMO        = 2000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Uart_Rx = 1'b1;
  logic [31:0] Disp_Data;
  logic        Frame_Done;
  logic        Frame_Err;
  logic [7:0]  Rx_Byte;
  logic        Rx_Byte_Valid;

  always #5 Clk = ~Clk;

  uart_disp_rx #(
    .CLOCK_FREQ   (CLOCK_FREQ),
    .BAUD         (BAUD),
    .FRAME_TIMEOUT(TMO),
    .HEADER       (8'hA5)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Uart_Rx      (Uart_Rx),
    .Disp_Data    (Disp_Data),
    .Frame_Done   (Frame_Done),
    .Frame_Err    (Frame_Err),
    .Rx_Byte      (Rx_Byte),
    .Rx_Byte_Valid(Rx_Byte_Valid)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_valid = 0;
  int          n_done = 0;
  int          n_err = 0;
  logic        prev_valid = 1'b0;
  logic [7:0]  byte_q[$];
  logic [31:0] disp_q[$];
  logic [7:0]  exp_b;
  logic [31:0] exp_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset) begin
      prev_valid = 1'b0;
    end else begin
      if (Rx_Byte_Valid) begin
        n_valid++;
        check("byte_expected", 32'(byte_q.size() != 0), 32'd1);
        if (byte_q.size() != 0) begin
          exp_b = byte_q.pop_front();
          check("rx_byte", {24'h0, Rx_Byte}, {24'h0, exp_b});
        end
      end
      if (Frame_Done) begin
        n_done++;
        check("done_after_valid", {31'h0, prev_valid}, 32'd1);
        check("frame_expected", 32'(disp_q.size() != 0), 32'd1);
        if (disp_q.size() != 0) begin
          exp_d = disp_q.pop_front();
          check("disp_data", Disp_Data, exp_d);
        end
      end
      if (Frame_Err) n_err++;
      prev_valid = Rx_Byte_Valid;
    end
  end

  task automatic send_bit(input logic b);
    Uart_Rx = b;
    repeat (BIT_CLKS) @(negedge Clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    if (stop_bit) byte_q.push_back(b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
    Uart_Rx = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] d, input logic good);
    logic [7:0] chk;
    chk = d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    if (!good) chk = chk ^ 8'h01;
    else       disp_q.push_back(d);
    send_byte(8'hA5);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    send_byte(chk);
  endtask

  int v0, d0, e0;

  initial begin
    // Reset state
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_disp", Disp_Data, 32'h0);
    check("rst_done", {31'h0, Frame_Done}, 32'd0);
    check("rst_err", {31'h0, Frame_Err}, 32'd0);
    check("rst_byte", {24'h0, Rx_Byte}, 32'h0);
    check("rst_valid", {31'h0, Rx_Byte_Valid}, 32'd0);
    Reset = 1'b0;
    repeat (10000) @(negedge Clk);
    check("idle_valid", n_valid, 0);
    check("idle_err", n_err, 0);
    check("idle_done", n_done, 0);

    // Good frame
    v0 = n_valid; d0 = n_done; e0 = n_err;
    send_frame(32'h12345678, 1'b1);
    repeat (40) @(negedge Clk);
    check("good_valid_cnt", n_valid - v0, 6);
    check("good_done_cnt", n_done - d0, 1);
    check("good_err_cnt", n_err - e0, 0);
    check("good_disp", Disp_Data, 32'h12345678);

    // Bad checksum
    d0 = n_done; e0 = n_err;
    send_frame(32'h12345678, 1'b0);
    repeat (40) @(negedge Clk);
    check("badchk_err_cnt", n_err - e0, 1);
    check("badchk_done_cnt", n_done - d0, 0);
    check("badchk_disp", Disp_Data, 32'h12345678);

    // Glitch rejection
    v0 = n_valid; e0 = n_err;
    Uart_Rx = 1'b0;
    repeat (4) @(negedge Clk);
    Uart_Rx = 1'b1;
    repeat (100) @(negedge Clk);
    check("glitch_valid_cnt", n_valid - v0, 0);
    check("glitch_err_cnt", n_err - e0, 0);

    // Header hunt; second A5 is payload
    d0 = n_done; e0 = n_err;
    send_byte(8'h00);
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    disp_q.push_back(32'hA5000000);
    send_byte(8'hA5);
    repeat (40) @(negedge Clk);
    check("hunt_done_cnt", n_done - d0, 1);
    check("hunt_err_cnt", n_err - e0, 0);
    check("hunt_disp", Disp_Data, 32'hA5000000);

    // Inter-byte timeout
    d0 = n_done; e0 = n_err;
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TMO + 200) @(negedge Clk);
    check("tmo_err_cnt", n_err - e0, 1);
    check("tmo_done_cnt", n_done - d0, 0);
    send_frame(32'hCAFEF00D, 1'b1);
    repeat (40) @(negedge Clk);
    check("tmo_recover_done", n_done - d0, 1);
    check("tmo_recover_disp", Disp_Data, 32'hCAFEF00D);

    // Stop-bit error
    v0 = n_valid; e0 = n_err;
    send_byte(8'h3C, 1'b0);
    repeat (40) @(negedge Clk);
    check("stop_err_cnt", n_err - e0, 1);
    check("stop_valid_cnt", n_valid - v0, 0);

    // Reset during the third data byte
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Uart_Rx = 1'b1;
    check("midrst_disp", Disp_Data, 32'h0);
    check("midrst_done", {31'h0, Frame_Done}, 32'd0);
    Reset = 1'b0;
    repeat (200) @(negedge Clk);
    check("midrst_byteq_empty", byte_q.size(), 0);
    d0 = n_done;
    send_frame(32'h87654321, 1'b1);
    repeat (40) @(negedge Clk);
    check("midrst_recover_done", n_done - d0, 1);
    check("midrst_recover_disp", Disp_Data, 32'h87654321);

    check("final_byteq_empty", byte_q.size(), 0);
    check("final_dispq_empty", disp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
